// File: rtl/wb2axi4l_bridge.sv
// Wishbone classic slave to AXI4-Lite master bridge, one outstanding transaction.
// Every output is a register; DONE turns the captured AXI response into a single ack or err pulse.
module wb2axi4l_bridge #(
    parameter int ADRWIDTH = 32,
    parameter int DATWIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADRWIDTH-1:0]     wb_adr_i,
    input  logic [DATWIDTH-1:0]     wb_dat_i,
    input  logic [DATWIDTH/8-1:0]   wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic [DATWIDTH-1:0]     wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [ADRWIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATWIDTH-1:0]     m_axi_wdata,
    output logic [DATWIDTH/8-1:0]   m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADRWIDTH-1:0]     m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATWIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                  state, state_n;
    logic [1:0]              resp, resp_n;
    logic [ADRWIDTH-1:0]     awaddr_n, araddr_n;
    logic [DATWIDTH-1:0]     wdata_n, dat_n;
    logic [DATWIDTH/8-1:0]   wstrb_n;
    logic                    awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic                    ack_n, err_n;
    logic                    aw_done, w_done, ar_done;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= IDLE;
            resp          <= 2'b00;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            wb_dat_o      <= '0;
            wb_ack_o      <= 1'b0;
            wb_err_o      <= 1'b0;
        end else begin
            state         <= state_n;
            resp          <= resp_n;
            m_axi_awaddr  <= awaddr_n;
            m_axi_araddr  <= araddr_n;
            m_axi_wdata   <= wdata_n;
            m_axi_wstrb   <= wstrb_n;
            m_axi_awvalid <= awvalid_n;
            m_axi_wvalid  <= wvalid_n;
            m_axi_bready  <= bready_n;
            m_axi_arvalid <= arvalid_n;
            m_axi_rready  <= rready_n;
            wb_dat_o      <= dat_n;
            wb_ack_o      <= ack_n;
            wb_err_o      <= err_n;
        end
    end

    // A channel counts as done once its valid has already dropped or is handshaking this cycle.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;
    assign ar_done = !m_axi_arvalid || m_axi_arready;

    always_comb begin
        state_n   = state;
        resp_n    = resp;
        awaddr_n  = m_axi_awaddr;
        araddr_n  = m_axi_araddr;
        wdata_n   = m_axi_wdata;
        wstrb_n   = m_axi_wstrb;
        awvalid_n = m_axi_awvalid;
        wvalid_n  = m_axi_wvalid;
        bready_n  = m_axi_bready;
        arvalid_n = m_axi_arvalid;
        rready_n  = m_axi_rready;
        dat_n     = wb_dat_o;
        ack_n     = 1'b0;
        err_n     = 1'b0;

        case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (wb_we_i) begin
                        awaddr_n  = wb_adr_i;
                        wdata_n   = wb_dat_i;
                        wstrb_n   = wb_sel_i;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        bready_n  = 1'b1;
                        state_n   = WR;
                    end else begin
                        araddr_n  = wb_adr_i;
                        arvalid_n = 1'b1;
                        rready_n  = 1'b1;
                        state_n   = RD_ADDR;
                    end
                end
            end
            WR: begin
                awvalid_n = m_axi_awvalid && !m_axi_awready;
                wvalid_n  = m_axi_wvalid  && !m_axi_wready;
                if (aw_done && w_done) begin
                    if (m_axi_bvalid) begin
                        resp_n   = m_axi_bresp;
                        bready_n = 1'b0;
                        state_n  = DONE;
                    end else begin
                        state_n  = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    resp_n   = m_axi_bresp;
                    bready_n = 1'b0;
                    state_n  = DONE;
                end
            end
            RD_ADDR: begin
                arvalid_n = m_axi_arvalid && !m_axi_arready;
                if (ar_done) begin
                    if (m_axi_rvalid) begin
                        dat_n    = m_axi_rdata;
                        resp_n   = m_axi_rresp;
                        rready_n = 1'b0;
                        state_n  = DONE;
                    end else begin
                        state_n  = RD_DATA;
                    end
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    dat_n    = m_axi_rdata;
                    resp_n   = m_axi_rresp;
                    rready_n = 1'b0;
                    state_n  = DONE;
                end
            end
            DONE: begin
                // An aborted master (cyc low) gets no termination pulse.
                ack_n   = wb_cyc_i && !resp[1];
                err_n   = wb_cyc_i &&  resp[1];
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb2axi4l_bridge.sv
// Randomised bench for wb2axi4l_bridge: a Wishbone master and a delay-programmable AXI4-Lite slave
// run against a word-memory model, with latency derived from the handshake schedule.
module tb_wb2axi4l_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    int checks = 0, failures = 0, txn = 0;
    int ack_cnt = 0, err_cnt = 0, both_cnt = 0, proto_bad = 0;
    logic [31:0] mem [0:15];
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] got_addr, got_wdata;
    logic [3:0]  got_wstrb;

    always #5 clk_i = ~clk_i;

    wb2axi4l_bridge #(.ADRWIDTH(32), .DATWIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always @(negedge clk_i) begin
        if (wb_ack_o) ack_cnt++;
        if (wb_err_o) err_cnt++;
        if (wb_ack_o && wb_err_o) both_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL txn%0d %s: got %h, want %h", txn, tag, actual, expected);
        end
    endtask

    // AXI slave channels: wait for valid, stall `dly` cycles, take one beat, and insist valid then drops.
    task automatic slaveAw(input int dly);
        int n = 0;
        while (!m_axi_awvalid && n < 50) begin @(negedge clk_i); n++; end
        for (int i = 0; i < dly; i++) begin
            @(negedge clk_i);
            if (!m_axi_awvalid) proto_bad++;
        end
        m_axi_awready = 1'b1;
        got_addr = m_axi_awaddr;
        @(negedge clk_i);
        m_axi_awready = 1'b0;
        if (m_axi_awvalid) proto_bad++;
    endtask

    task automatic slaveW(input int dly);
        int n = 0;
        while (!m_axi_wvalid && n < 50) begin @(negedge clk_i); n++; end
        for (int i = 0; i < dly; i++) begin
            @(negedge clk_i);
            if (!m_axi_wvalid) proto_bad++;
        end
        m_axi_wready = 1'b1;
        got_wdata = m_axi_wdata;
        got_wstrb = m_axi_wstrb;
        @(negedge clk_i);
        m_axi_wready = 1'b0;
        if (m_axi_wvalid) proto_bad++;
    endtask

    task automatic slaveB(input int dly, input logic [1:0] resp);
        int n = 0;
        repeat (dly) @(negedge clk_i);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = resp;
        while (!m_axi_bready && n < 50) begin @(negedge clk_i); n++; end
        @(negedge clk_i);
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        if (m_axi_bready) proto_bad++;
    endtask

    task automatic slaveR(input int ar_dly, input int r_dly, input logic [1:0] resp, input logic [31:0] rdata);
        int n = 0;
        while (!m_axi_arvalid && n < 50) begin @(negedge clk_i); n++; end
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk_i);
            if (!m_axi_arvalid) proto_bad++;
        end
        m_axi_arready = 1'b1;
        got_addr = m_axi_araddr;
        @(negedge clk_i);
        m_axi_arready = 1'b0;
        if (m_axi_arvalid) proto_bad++;
        repeat (r_dly) @(negedge clk_i);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = rdata;
        m_axi_rresp  = resp;
        n = 0;
        while (!m_axi_rready && n < 50) begin @(negedge clk_i); n++; end
        @(negedge clk_i);
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
        if (m_axi_rready) proto_bad++;
    endtask

    task automatic wbStart(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
    endtask

    // Wishbone inputs are scrambled while the bridge is busy; the latched AXI values must not follow.
    task automatic wbWait(input logic hold, output int lat, output logic acked, output logic errd);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
            if (!wb_ack_o && !wb_err_o) begin
                wb_adr_i = $urandom;
                wb_dat_i = $urandom;
                wb_sel_i = 4'($urandom);
            end
        end while (!wb_ack_o && !wb_err_o && n < 100);
        acked = wb_ack_o;
        errd  = wb_err_o;
        lat   = n - 1;
        if (!hold) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int d1, input int d2, input int d3,
                                 input logic [1:0] resp, input logic hold);
        int a0 = ack_cnt, e0 = err_cnt, p0 = proto_bad;
        int idx = int'(adr[5:2]);
        int lat, exp_lat;
        logic acked, errd;
        logic [31:0] rdata;
        txn++;
        rdata = resp[1] ? 32'($urandom) : mem[idx];
        wbStart(we, adr, dat, sel);
        fork
            begin
                if (we) begin
                    fork
                        slaveAw(d1);
                        slaveW(d2);
                    join
                    slaveB(d3, resp);
                end else begin
                    slaveR(d1, d2, resp, rdata);
                end
            end
            wbWait(hold, lat, acked, errd);
        join
        #1;
        exp_lat = we ? ((d1 > d2 ? d1 : d2) + d3 + 3) : (d1 + d2 + 3);
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("ack", 32'(acked), 32'(!resp[1]));
        checkOutput("err", 32'(errd), 32'(resp[1]));
        checkOutput("ack_pulses", 32'(ack_cnt - a0), 32'(!resp[1]));
        checkOutput("err_pulses", 32'(err_cnt - e0), 32'(resp[1]));
        checkOutput("axi_protocol", 32'(proto_bad - p0), 32'd0);
        checkOutput("axi_addr", got_addr, adr);
        if (we) begin
            checkOutput("wdata", got_wdata, dat);
            checkOutput("wstrb", 32'(got_wstrb), 32'(sel));
            if (!resp[1])
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mem[idx][8*b +: 8] = dat[8*b +: 8];
        end else begin
            last_rdata = rdata;
        end
        checkOutput("wb_dat_o", wb_dat_o, last_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0, e0;
        rst_ni = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[8] = 32'h1234_5678;

        repeat (3) @(negedge clk_i);
        checkOutput("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
        checkOutput("rst_wvalid",  32'(m_axi_wvalid),  32'd0);
        checkOutput("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        checkOutput("rst_bready",  32'(m_axi_bready),  32'd0);
        checkOutput("rst_rready",  32'(m_axi_rready),  32'd0);
        checkOutput("rst_ack_err", 32'({wb_ack_o, wb_err_o}), 32'd0);
        checkOutput("rst_awaddr",  m_axi_awaddr, 32'd0);
        checkOutput("rst_araddr",  m_axi_araddr, 32'd0);
        checkOutput("rst_wdata",   m_axi_wdata,  32'd0);
        checkOutput("rst_wstrb",   32'(m_axi_wstrb), 32'd0);
        checkOutput("rst_dat_o",   wb_dat_o,     32'd0);
        checkOutput("prot",        32'({m_axi_awprot, m_axi_arprot}), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        applyStimulus(1'b1, 32'h7000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        applyStimulus(1'b0, 32'h7000_0020, 32'h0, 4'hF, 0, 5, 0, 2'b00, 1'b0);
        applyStimulus(1'b1, 32'h7000_0040, 32'hCAFE_F00D, 4'b0011, 4, 0, 1, 2'b00, 1'b0);
        applyStimulus(1'b1, 32'h7000_0044, 32'h1111_2222, 4'hF, 1, 2, 0, 2'b10, 1'b0);
        applyStimulus(1'b0, 32'h7000_0048, 32'h0, 4'hF, 2, 1, 0, 2'b11, 1'b0);
        applyStimulus(1'b1, 32'h7000_004C, 32'h3333_4444, 4'hF, 0, 0, 0, 2'b01, 1'b0);

        // Reset while the read waits for data; a late rvalid must be ignored.
        txn++;
        a0 = ack_cnt; e0 = err_cnt;
        wbStart(1'b0, 32'h7000_0030, 32'h0, 4'hF);
        @(negedge clk_i);
        checkOutput("rstmid_arvalid", 32'(m_axi_arvalid), 32'd1);
        m_axi_arready = 1'b1;
        @(negedge clk_i);
        m_axi_arready = 1'b0;
        checkOutput("rstmid_rready_busy", 32'(m_axi_rready), 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        checkOutput("rstmid_rready", 32'(m_axi_rready), 32'd0);
        checkOutput("rstmid_dat_o", wb_dat_o, 32'd0);
        last_rdata = 32'h0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hBAD0_BAD0;
        repeat (3) @(negedge clk_i);
        checkOutput("rstmid_late_rready", 32'(m_axi_rready), 32'd0);
        m_axi_rvalid = 1'b0;
        #1;
        checkOutput("rstmid_no_term", 32'((ack_cnt - a0) + (err_cnt - e0)), 32'd0);
        @(negedge clk_i);
        applyStimulus(1'b0, 32'h7000_0030, 32'h0, 4'hF, 1, 1, 0, 2'b00, 1'b0);

        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 32'(i * 4), 32'($urandom), 4'hF, 0, 0, 0, 2'b00, i != 7);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 32'(i * 4), 32'h0, 4'hF, 0, 0, 0, 2'b00, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] resp;
            logic [3:0] sel;
            resp = ($urandom % 6 == 0) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
            sel  = 4'($urandom_range(1, 15));
            applyStimulus(1'($urandom), 32'h4000_0000 | 32'(($urandom % 16) * 4), 32'($urandom), sel,
                          int'($urandom % 4), int'($urandom % 4), int'($urandom % 4), resp, 1'b0);
            repeat ($urandom % 3) @(negedge clk_i);
        end

        checkOutput("ack_err_overlap", 32'(both_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
